// File: rtl/rand_bounded.sv
// Bounded uniform integer generator fed by a free-running LFSR (optional stats: RAND_BOUNDED_STATS_EN).
// Decimated capture, power-of-two masking, rejection sampling, show-ahead output FIFO.
module rand_bounded #(
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int STRIDE     = OUT_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     lfsr_state,
  input  logic                 enable,
  input  logic [OUT_WIDTH-1:0] bound,
  input  logic                 bound_load,
  output logic                 rand_valid,
  input  logic                 rand_ready,
  output logic [OUT_WIDTH-1:0] rand_data
`ifdef RAND_BOUNDED_STATS_EN
  ,
  output logic [15:0]          reject_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST = 8'(STRIDE - 1);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]  cand_q, cand_d;
  logic [OUT_WIDTH-1:0]  bound_q, bound_d;
  logic [OUT_WIDTH-1:0]  mask_q, mask_d;
  logic [OUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [PW:0]           count_q, count_d;

  logic push;
  logic pop;
  logic reject;
  logic accept;
  logic full;

  // Smallest all-ones pattern covering bound-1; zero bound means full range.
  function automatic logic [OUT_WIDTH-1:0] mask_of(
    input logic [OUT_WIDTH-1:0] b
  );
    logic [OUT_WIDTH-1:0] m;
    logic [OUT_WIDTH-1:0] lim;
    m   = '0;
    lim = b - OUT_WIDTH'(1);
    if (b == '0) begin
      m = '1;
    end else begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
        if (m < lim) m = (m << 1) | OUT_WIDTH'(1);
      end
    end
    return m;
  endfunction

  generate
    if (WIDTH > OUT_WIDTH) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^lfsr_state[WIDTH-1:OUT_WIDTH];
    end
  endgenerate

  assign rand_valid = (count_q != '0);
  assign rand_data  = rand_valid ? mem_q[rd_q] : '0;
  assign pop        = rand_valid & rand_ready;
  assign full       = (count_q == DEPTH_C);
  assign accept     = (bound_q == '0) || (cand_q < bound_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    mem_d   = mem_q;
    push    = 1'b0;
    reject  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == LAST) begin
          cand_d  = lfsr_state[OUT_WIDTH-1:0] & mask_q;
          cnt_d   = '0;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EVAL: begin
        // A full FIFO parks the accepted candidate here until space frees.
        if (accept && full) begin
          state_d = EVAL;
        end else begin
          push    = accept;
          reject  = !accept;
          state_d = enable ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) mem_d[wr_q] = cand_q;
    wr_d    = wr_q + PW'(push);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);

    if (bound_load) begin
      bound_d = bound;
      mask_d  = mask_of(bound);
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      cnt_d   = '0;
      cand_d  = '0;
      state_d = enable ? COLLECT : IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      bound_q <= '0;
      mask_q  <= '1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      bound_q <= bound_d;
      mask_q  <= mask_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

`ifdef RAND_BOUNDED_STATS_EN
  logic [15:0] rej_q, rej_d;

  always_comb begin
    rej_d = rej_q;
    if (reject && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    if (bound_load) rej_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rej_q <= '0;
    else       rej_q <= rej_d;
  end

  assign reject_count = rej_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_rand_bounded.sv
// Self-checking bench for rand_bounded: vector table, directed corner
// sequences and a randomized run against a capture-schedule model.
module tb_rand_bounded;

  logic        clk;
  logic        reset;
  logic [15:0] lfsr_state;
  logic        enable;
  logic [7:0]  bound;
  logic        bound_load;
  logic        rand_valid;
  logic        rand_ready;
  logic [7:0]  rand_data;
`ifdef RAND_BOUNDED_STATS_EN
  logic [15:0] reject_count;
`endif

  int errors = 0;
  int checks = 0;

  rand_bounded dut (
    .clk        (clk),
    .reset      (reset),
    .lfsr_state (lfsr_state),
    .enable     (enable),
    .bound      (bound),
    .bound_load (bound_load),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .rand_data  (rand_data)
`ifdef RAND_BOUNDED_STATS_EN
    ,
    .reject_count (reject_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [15:0] lfsr;
    logic        v;
    logic [7:0]  d;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_mask(input int b);
    int k;
    if (b == 0) return 255;
    k = 0;
    while ((1 << k) - 1 < b - 1) k++;
    return (1 << k) - 1;
  endfunction

  // Output schedule: with the consumer always ready, one capture every
  // 9 clocks (edge 8 mod 9), result visible one clock later if accepted.
  task automatic run_model(input int b, input int ncap);
    int m, v, capv, rej;
    bit have_cap, expv;
    int expd;
    m = model_mask(b);
    bound      = 8'(b);
    bound_load = 1'b1;
    enable     = 1'b1;
    rand_ready = 1'b1;
    lfsr_state = 16'($urandom);
    tick();
    bound_load = 1'b0;
    check("load_valid", {rand_valid, rand_data}, 9'h0);
`ifdef RAND_BOUNDED_STATS_EN
    check("load_rejcnt", reject_count, 0);
`endif
    have_cap = 0;
    capv = 0;
    rej = 0;
    for (int j = 1; j <= ncap * 9; j++) begin
      lfsr_state = 16'($urandom);
      v = int'(lfsr_state[7:0]) & m;
      expv = 0;
      expd = 0;
      if (have_cap) begin
        if (b == 0 || capv < b) begin
          expv = 1;
          expd = capv;
        end else begin
          rej++;
        end
        have_cap = 0;
      end
      if (j % 9 == 8) begin
        have_cap = 1;
        capv = v;
      end
      tick();
      check("rnd_out", {rand_valid, rand_data}, {expv, 8'(expd)});
      if (rand_valid && b != 0)
        check("rnd_lt_bound", 32'(rand_data < 8'(b)), 1);
    end
`ifdef RAND_BOUNDED_STATS_EN
    check("rnd_rejcnt", reject_count, rej);
`endif
  endtask

  logic [7:0] caps[5];
  int ncaps;

  initial begin
    vecs[0]  = '{8'd0,   16'hA5C3, 1'b1, 8'hC3};
    vecs[1]  = '{8'd10,  16'h00C3, 1'b1, 8'h03};
    vecs[2]  = '{8'd10,  16'h000C, 1'b0, 8'h00};
    vecs[3]  = '{8'd1,   16'hFFFF, 1'b1, 8'h00};
    vecs[4]  = '{8'd200, 16'h00C7, 1'b1, 8'hC7};
    vecs[5]  = '{8'd200, 16'h00C8, 1'b0, 8'h00};
    vecs[6]  = '{8'd5,   16'h0004, 1'b1, 8'h04};
    vecs[7]  = '{8'd5,   16'h0006, 1'b0, 8'h00};
    vecs[8]  = '{8'd2,   16'h0003, 1'b1, 8'h01};
    vecs[9]  = '{8'd128, 16'h00FF, 1'b1, 8'h7F};
    vecs[10] = '{8'd129, 16'h00FF, 1'b0, 8'h00};
    vecs[11] = '{8'd255, 16'h80FE, 1'b1, 8'hFE};

    reset      = 1'b1;
    lfsr_state = 16'h0;
    enable     = 1'b0;
    bound      = 8'h0;
    bound_load = 1'b0;
    rand_ready = 1'b0;
    #12;
    check("reset_out", {rand_valid, rand_data}, 9'h0);
    tick();
    reset = 1'b0;
    tick();

    // Single-shot latency and accept/reject table
    for (int i = 0; i < 12; i++) begin
      bound      = vecs[i].b;
      lfsr_state = vecs[i].lfsr;
      bound_load = 1'b1;
      enable     = 1'b1;
      rand_ready = 1'b1;
      tick();
      bound_load = 1'b0;
      repeat (8) tick();
      check($sformatf("vec%0d_early", i), rand_valid, 0);
      tick();
      check($sformatf("vec%0d_out", i), {rand_valid, rand_data},
            {vecs[i].v, vecs[i].d});
`ifdef RAND_BOUNDED_STATS_EN
      check($sformatf("vec%0d_rej", i), reject_count, {15'h0, !vecs[i].v});
`endif
    end

    // Backpressure: 4 buffered, 5th parked, one pop then held push
    bound      = 8'd0;
    bound_load = 1'b1;
    enable     = 1'b1;
    rand_ready = 1'b0;
    tick();
    bound_load = 1'b0;
    ncaps = 0;
    for (int j = 1; j <= 60; j++) begin
      lfsr_state = 16'($urandom);
      if (j % 9 == 8 && ncaps < 5) begin
        caps[ncaps] = lfsr_state[7:0];
        ncaps++;
      end
      tick();
    end
    check("bp_head", {rand_valid, rand_data}, {1'b1, caps[0]});
    rand_ready = 1'b1;
    enable     = 1'b0;
    tick();
    check("bp_pop", {rand_valid, rand_data}, {1'b1, caps[1]});
    rand_ready = 1'b0;
    tick();
    check("bp_hold", {rand_valid, rand_data}, {1'b1, caps[1]});
    rand_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("bp_drain%0d", k), {rand_valid, rand_data},
            {1'b1, caps[k]});
      tick();
    end
    check("bp_empty", {rand_valid, rand_data}, 9'h0);

    // Randomized runs across bounds
    run_model(1, 100);
    run_model(200, 1000);
    run_model(10, 100);
    run_model(0, 50);

    // Fill 3 entries (one reject first), then bound_load flushes
    bound      = 8'd200;
    bound_load = 1'b1;
    enable     = 1'b1;
    rand_ready = 1'b0;
    tick();
    bound_load = 1'b0;
    for (int j = 1; j <= 36; j++) begin
      lfsr_state = (j == 8) ? 16'h00F0 : 16'h0011;
      tick();
    end
    check("fill3_valid", {rand_valid, rand_data}, {1'b1, 8'h11});
`ifdef RAND_BOUNDED_STATS_EN
    check("fill3_rej", reject_count, 1);
`endif
    run_model(5, 100);

    // Asynchronous reset mid-COLLECT with FIFO non-empty
    bound      = 8'd0;
    bound_load = 1'b1;
    enable     = 1'b1;
    rand_ready = 1'b0;
    lfsr_state = 16'h0077;
    tick();
    bound_load = 1'b0;
    repeat (12) tick();
    check("pre_rst", {rand_valid, rand_data}, {1'b1, 8'h77});
    #3;
    reset = 1'b1;
    #1;
    check("async_rst", {rand_valid, rand_data}, 9'h0);
    tick();
    reset      = 1'b0;
    lfsr_state = 16'h1234;
    rand_ready = 1'b1;
    tick();
    repeat (8) tick();
    check("rst_early", rand_valid, 0);
    tick();
    check("rst_first", {rand_valid, rand_data}, {1'b1, 8'h34});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
